// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   Two-digit loadable down-counter driven by an upstream rollover tick.
//   The low digit counts modulo k_lo and the high digit modulo k_hi, with a
//   borrow from low to high. Counting stops at 00 and the expiry is reported
//   with a one-cycle done pulse.
//
// Ports
//   Clock    in   system clock, all state changes on posedge
//   Reset    in   synchronous active-high reset
//   tick     in   one-cycle count enable
//   load     in   load preset (saturated to the digit moduli), go IDLE
//   load_hi  in   [n] high digit preset
//   load_lo  in   [n] low digit preset
//   start    in   begin/resume counting when the count is non-zero
//   pause    in   suspend counting
//   Q_hi     out  [n] current high digit (registered)
//   Q_lo     out  [n] current low digit (registered)
//   borrow   out  one-cycle pulse when the low digit wraps 0 -> k_lo-1
//   running  out  registered decode of the RUN state
//   done     out  one-cycle pulse on expiry
//
// Per-edge priority: Reset > load > pause > start > tick.

module bcd_countdown_timer #(
    parameter int n    = 4,
    parameter int k_lo = 10,
    parameter int k_hi = 6
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         tick,
    input  logic         load,
    input  logic [n-1:0] load_hi,
    input  logic [n-1:0] load_lo,
    input  logic         start,
    input  logic         pause,
    output logic [n-1:0] Q_hi,
    output logic [n-1:0] Q_lo,
    output logic         borrow,
    output logic         running,
    output logic         done
);

    generate
        if ((k_lo < 1) || (k_hi < 1) || (k_lo > (1 << n)) || (k_hi > (1 << n))) begin : g_bad_modulus
            $error("bcd_countdown_timer: k_lo and k_hi must be in 1..2**n");
        end
    endgenerate

    localparam logic [n-1:0] LO_MAX = n'(k_lo - 1);
    localparam logic [n-1:0] HI_MAX = n'(k_hi - 1);
    localparam logic [n-1:0] ONE    = n'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    state_t       state_q, state_d;
    logic [n-1:0] q_hi_d, q_lo_d;
    logic         borrow_d, done_d;
    logic         count_zero;

    assign count_zero = (Q_hi == '0) && (Q_lo == '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            Q_hi    <= '0;
            Q_lo    <= '0;
            borrow  <= 1'b0;
            done    <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            Q_hi    <= q_hi_d;
            Q_lo    <= q_lo_d;
            borrow  <= borrow_d;
            done    <= done_d;
            running <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d  = state_q;
        q_hi_d   = Q_hi;
        q_lo_d   = Q_lo;
        borrow_d = 1'b0;
        done_d   = 1'b0;

        if (load) begin
            q_lo_d  = (load_lo > LO_MAX) ? LO_MAX : load_lo;
            q_hi_d  = (load_hi > HI_MAX) ? HI_MAX : load_hi;
            state_d = IDLE;
        end else if (pause) begin
            // pause claims the cycle in every state, so a simultaneous start
            // is always dropped; it only changes state when RUN.
            if (state_q == RUN) begin
                state_d = PAUSED;
            end
        end else begin
            unique case (state_q)
                IDLE, PAUSED: begin
                    if (start && !count_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (Q_lo != '0) begin
                            q_lo_d = Q_lo - ONE;
                            if ((Q_hi == '0) && (Q_lo == ONE)) begin
                                state_d = EXPIRED;
                                done_d  = 1'b1;
                            end
                        end else if (Q_hi != '0) begin
                            q_lo_d   = LO_MAX;
                            q_hi_d   = Q_hi - ONE;
                            borrow_d = 1'b1;
                        end else begin
                            // 00 while RUN is unreachable; settle as expired
                            // rather than wrapping.
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    q_hi_d = '0;
                    q_lo_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer
//   Directed-vector bench for bcd_countdown_timer (n=4, k_lo=10, k_hi=6).
//   Inputs are applied 1 ns after a rising edge, held for one clock, and the
//   registered outputs are sampled 1 ns after the next rising edge.

module tb_bcd_countdown_timer;

    localparam int N = 4;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         tick  = 1'b0;
    logic         load  = 1'b0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic [N-1:0] load_hi = '0;
    logic [N-1:0] load_lo = '0;
    logic [N-1:0] Q_hi, Q_lo;
    logic         borrow, running, done;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    bcd_countdown_timer #(
        .n    (N),
        .k_lo (10),
        .k_hi (6)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .tick    (tick),
        .load    (load),
        .load_hi (load_hi),
        .load_lo (load_lo),
        .start   (start),
        .pause   (pause),
        .Q_hi    (Q_hi),
        .Q_lo    (Q_lo),
        .borrow  (borrow),
        .running (running),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock with the currently driven inputs, then release all strobes.
    task automatic clk1();
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        tick  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic do_load(input logic [N-1:0] hi, input logic [N-1:0] lo);
        load    = 1'b1;
        load_hi = hi;
        load_lo = lo;
        clk1();
    endtask

    task automatic check_q(input string tag, input int hi, input int lo);
        check({tag, "_hi"}, 32'(Q_hi), 32'(hi));
        check({tag, "_lo"}, 32'(Q_lo), 32'(lo));
    endtask

    int nb, nd, nboth;

    initial begin
        // Power-on reset
        Reset = 1'b1; clk1();
        Reset = 1'b1; clk1();
        check_q("por", 0, 0);
        check("por_running", 32'(running), 0);
        check("por_done", 32'(done), 0);
        check("por_borrow", 32'(borrow), 0);

        // Reset held two cycles mid-RUN at 3,7
        do_load(4'd3, 4'd7);
        start = 1'b1; clk1();
        check("rst_pre_running", 32'(running), 1);
        check_q("rst_pre", 3, 7);
        Reset = 1'b1; tick = 1'b1; clk1();
        Reset = 1'b1; tick = 1'b1; clk1();
        check_q("rst_mid", 0, 0);
        check("rst_mid_running", 32'(running), 0);
        check("rst_mid_done", 32'(done), 0);
        tick = 1'b1; clk1();
        tick = 1'b1; clk1();
        check_q("rst_tick", 0, 0);
        check("rst_tick_running", 32'(running), 0);

        // load 0,3; three ticks spaced four cycles apart
        do_load(4'd0, 4'd3);
        check_q("l03", 0, 3);
        check("l03_running", 32'(running), 0);
        start = 1'b1; clk1();
        check("l03_start_running", 32'(running), 1);
        for (int i = 0; i < 3; i++) begin
            clk1(); clk1(); clk1();
            tick = 1'b1; clk1();
            check_q($sformatf("l03_t%0d", i), 0, 2 - i);
            check($sformatf("l03_t%0d_done", i), 32'(done), (i == 2) ? 1 : 0);
            check($sformatf("l03_t%0d_borrow", i), 32'(borrow), 0);
        end
        check("l03_exp_running", 32'(running), 0);
        clk1();
        check("l03_done_gone", 32'(done), 0);
        tick = 1'b1; clk1();
        check_q("l03_exp_hold", 0, 0);
        check("l03_exp_done", 32'(done), 0);
        start = 1'b1; clk1();
        check("l03_exp_start_running", 32'(running), 0);

        // In EXPIRED: load 0,2 together with tick
        load = 1'b1; load_hi = 4'd0; load_lo = 4'd2; tick = 1'b1; clk1();
        check_q("exp_load", 0, 2);
        check("exp_load_running", 32'(running), 0);
        tick = 1'b1; clk1();
        check_q("exp_load_idle_tick", 0, 2);

        // load 1,0; first tick borrows, then 9 more to expiry
        do_load(4'd1, 4'd0);
        start = 1'b1; clk1();
        tick = 1'b1; clk1();
        check_q("l10_t0", 0, 9);
        check("l10_t0_borrow", 32'(borrow), 1);
        clk1();
        check("l10_borrow_gone", 32'(borrow), 0);
        nb = 0; nd = 0;
        for (int i = 0; i < 9; i++) begin
            tick = 1'b1; clk1();
            nb += int'(borrow);
            nd += int'(done);
        end
        check_q("l10_end", 0, 0);
        check("l10_end_done", 32'(done), 1);
        clk1();
        nb += int'(borrow);
        nd += int'(done);
        check("l10_borrows", 32'(nb), 0);
        check("l10_dones", 32'(nd), 1);

        // Out-of-range preset saturates to 5,9; 59 back-to-back ticks
        do_load(4'd9, 4'd15);
        check_q("sat", 5, 9);
        start = 1'b1; clk1();
        nb = 0; nd = 0; nboth = 0;
        for (int i = 0; i < 59; i++) begin
            tick = 1'b1; clk1();
            nb += int'(borrow);
            nd += int'(done);
            nboth += int'(borrow & done);
            if (i == 9) check_q("sat_t9", 4, 9);
        end
        check_q("sat_end", 0, 0);
        check("sat_end_done", 32'(done), 1);
        check("sat_end_running", 32'(running), 0);
        tick = 1'b1; clk1();
        nd += int'(done);
        check("sat_borrows", 32'(nb), 5);
        check("sat_dones", 32'(nd), 1);
        check("sat_both", 32'(nboth), 0);

        // RUN at 2,5: pause+start+tick -> PAUSED, no decrement
        do_load(4'd2, 4'd5);
        start = 1'b1; clk1();
        check("pz_run", 32'(running), 1);
        pause = 1'b1; start = 1'b1; tick = 1'b1; clk1();
        check_q("pz_paused", 2, 5);
        check("pz_paused_running", 32'(running), 0);
        tick = 1'b1; clk1();
        tick = 1'b1; clk1();
        check_q("pz_paused_ticks", 2, 5);
        start = 1'b1; clk1();
        check("pz_resume_running", 32'(running), 1);
        check_q("pz_resume", 2, 5);
        tick = 1'b1; clk1();
        check_q("pz_tick", 2, 4);

        // load 0,0; start stays IDLE, no done
        do_load(4'd0, 4'd0);
        start = 1'b1; clk1();
        check("z_running", 32'(running), 0);
        check("z_done", 32'(done), 0);
        tick = 1'b1; clk1();
        check("z_done2", 32'(done), 0);
        check_q("z_hold", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Two-digit, loadable down-counter that consumes the one-cycle `tick` pulse produced by the team's mod-k up-counters (their rollover output).
- Counts a preset value (e.g. seconds 00–59) down to zero and reports expiry.
- Default configuration: low digit is mod-10, high digit is mod-6; borrow propagates from low digit to high digit.
- Sits between the timebase counter and the display/control logic of the lab timer design.

Parameters:
- n, 4, bit width of each digit register.
- k_lo, 10, modulus of low digit; legal values 0..k_lo-1.
- k_hi, 6, modulus of high digit; legal values 0..k_hi-1.

Ports:
- Clock  input  1  system clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle count enable (from upstream rollover).
- load  input  1  load preset from load_hi/load_lo.
- load_hi  input  n  preset for high digit.
- load_lo  input  n  preset for low digit.
- start  input  1  begin/resume counting.
- pause  input  1  suspend counting.
- Q_hi  output  n  current high digit (registered).
- Q_lo  output  n  current low digit (registered).
- borrow  output  1  one-cycle pulse when the low digit wraps 0 -> k_lo-1.
- running  output  1  high while state == RUN.
- done  output  1  one-cycle pulse on expiry.

Behaviour:
- Interface (already decided): one clock, Clock; reset is synchronous and active-high, port Reset. It is sampled only on posedge Clock.
- Reset values: Q_hi=0, Q_lo=0, borrow=0, running=0, done=0, state=IDLE. Reset overrides every other input in the same edge.
- States: IDLE, RUN, PAUSED, EXPIRED. running is a registered decode of RUN.
- Priority per edge: Reset > load > pause > start > tick.
- load, any state:
  - Q_lo <= min(load_lo, k_lo-1); Q_hi <= min(load_hi, k_hi-1). Out-of-range presets saturate.
  - Next state is IDLE; borrow=0, done=0.
  - tick in the same cycle is ignored.
- start:
  - From IDLE or PAUSED with count != 00 -> RUN.
  - With count == 00 -> no state change and no done.
  - Ignored in RUN and EXPIRED.
- pause:
  - RUN -> PAUSED. Ignored elsewhere.
  - pause and start in the same cycle: pause wins.
- tick in RUN, decrement with borrow:
  - If Q_lo != 0: Q_lo <= Q_lo-1.
  - Else: Q_lo <= k_lo-1, Q_hi <= Q_hi-1, borrow <= 1 for exactly one cycle.
  - tick outside RUN has no effect.
- Expiry:
  - A tick in RUN with count == 0,1 (Q_hi=0, Q_lo=1) sets count to 00 and state to EXPIRED.
  - done is registered: it is high in the cycle immediately after that edge, for exactly one cycle.
  - borrow is not asserted on expiry.
- EXPIRED: count holds 00. Only load or Reset leave it; load -> IDLE.
- Latency:
  - Q, borrow, done and running all update on the edge that samples the causing input (registered, one-cycle latency).
  - No combinational path from inputs to outputs.
- Back-to-back ticks on consecutive cycles must each decrement.
- borrow and done are never high in the same cycle.
- Widths: digits are unsigned n-bit. Comparisons against k_lo-1 and k_hi-1 are done at n bits.
- Elaboration check: k_lo and k_hi must each be <= 2**n.

Test Plan:
- Reset held 2 cycles mid-RUN at 3,7 -> next cycle Q_hi=0, Q_lo=0, running=0, done=0, state IDLE; following ticks have no effect.
- load 0,3; start; 3 ticks spaced 4 cycles apart:
  - Q_lo steps 2,1,0.
  - done high exactly one cycle after the 3rd tick.
  - running=0 and count holds 00 thereafter.
- load 1,0; start; 1 tick -> Q=0,9 with borrow high one cycle. Then 9 more ticks -> done once, borrow never high again.
- load 9,15 (out of range) -> Q_hi=5, Q_lo=9. start plus 59 consecutive-cycle ticks -> 00 reached, done pulse, 5 borrow pulses in total.
- RUN at 2,5; pause and start asserted together with tick -> state PAUSED, count stays 2,5. Ticks while PAUSED leave 2,5; start -> RUN; next tick -> 2,4.
- load 0,0; start -> state stays IDLE, no done.
- In EXPIRED, load 0,2 together with tick -> Q=0,2, state IDLE, no decrement.
